// File: rtl/me_lsu_if.sv
// Data-memory bus between the ME stage (master) and data memory (slave).
//
// Handshake: the master raises dm_req with dm_we/dm_addr/dm_wdata/dm_be and keeps
// all of them stable until the slave answers with dm_ack. dm_ack is a single-cycle
// completion pulse; for loads dm_rdata is valid in that same cycle. dm_req drops on
// the edge where dm_ack is sampled, so each request gets exactly one acknowledge.
interface me_lsu_if #(
   parameter int ADDR_W = 32
);
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [3:0]        dm_be;
   logic              dm_ack;
   logic [31:0]       dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/me_lsu.sv
// RV32I memory-access stage: aligns store data, builds byte enables, runs one
// request/acknowledge transaction per load/store and extends loaded data. Non-memory
// instructions pass the register-write triple straight through.
module me_lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_w_enable,
   input  logic [4:0]        ex_w_addr,
   input  logic [31:0]       ex_w_data,
   input  logic [3:0]        ex_mem_op,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       ex_mem_wdata,
   input  logic [5:0]        stall,
   output logic              me_w_enable,
   output logic [4:0]        me_w_addr,
   output logic [31:0]       me_w_data,
   output logic              stallreq_me,
   output logic              misalign_exc,
   output logic [1:0]        dbg_state,
   me_lsu_if.master          dm
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t      state_q, state_d;
   logic [31:0] rdata_q;

   logic        is_load, is_store, is_signed, is_mem, misaligned;
   logic [1:0]  size;
   logic [1:0]  lane;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic        issue, ack_take;

   // Only the ME-hold bit of the stall vector matters to this stage.
   logic        stall_unused;
   assign stall_unused = ^{stall[5], stall[3:0]};

   assign lane      = ex_mem_addr[1:0];
   assign dbg_state = state_q;

   // Decode the memory op; unknown encodings behave as NONE.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_signed = 1'b0;
      size      = SZ_BYTE;
      case (ex_mem_op)
         4'd1: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
         4'd2: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
         4'd3: begin is_load  = 1'b1; size = SZ_WORD; end
         4'd4: begin is_load  = 1'b1; size = SZ_BYTE; end
         4'd5: begin is_load  = 1'b1; size = SZ_HALF; end
         4'd6: begin is_store = 1'b1; size = SZ_BYTE; end
         4'd7: begin is_store = 1'b1; size = SZ_HALF; end
         4'd8: begin is_store = 1'b1; size = SZ_WORD; end
         default: ;
      endcase
   end

   assign is_mem     = is_load | is_store;
   assign misaligned = is_mem &&
                       (((size == SZ_HALF) && ex_mem_addr[0]) ||
                        ((size == SZ_WORD) && (ex_mem_addr[1:0] != 2'b00)));

   // Byte enables and lane-replicated store data for the access being issued.
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = 32'h0;
      case (size)
         SZ_BYTE: begin
            be_c    = 4'b0001 << lane;
            wdata_c = {4{ex_mem_wdata[7:0]}};
         end
         SZ_HALF: begin
            be_c    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{ex_mem_wdata[15:0]}};
         end
         SZ_WORD: begin
            be_c    = 4'b1111;
            wdata_c = ex_mem_wdata;
         end
         default: ;
      endcase
      if (!is_store) wdata_c = 32'h0;
   end

   // Extract and extend the loaded value from the captured read word.
   always_comb begin
      shifted   = rdata_q >> {lane, 3'b000};
      load_data = rdata_q;
      case (size)
         SZ_BYTE: load_data = is_signed ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'h0, shifted[7:0]};
         SZ_HALF: begin
            if (ex_mem_addr[1])
               load_data = is_signed ? {{16{rdata_q[31]}}, rdata_q[31:16]}
                                     : {16'h0, rdata_q[31:16]};
            else
               load_data = is_signed ? {{16{rdata_q[15]}}, rdata_q[15:0]}
                                     : {16'h0, rdata_q[15:0]};
         end
         default: load_data = rdata_q;
      endcase
   end

   assign ack_take = (state_q == REQ) && dm.dm_ack;

   // Next-state and stage outputs; reset forces every output low.
   always_comb begin
      state_d      = state_q;
      stallreq_me  = 1'b0;
      misalign_exc = 1'b0;
      me_w_enable  = 1'b0;
      me_w_addr    = ex_w_addr;
      me_w_data    = ex_w_data;
      issue        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!is_mem) begin
               me_w_enable = ex_w_enable;
            end else if (misaligned) begin
               misalign_exc = 1'b1;
            end else begin
               stallreq_me = 1'b1;
               issue       = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            stallreq_me = 1'b1;
            if (dm.dm_ack) state_d = DONE;
         end
         DONE: begin
            if (is_load) begin
               me_w_enable = ex_w_enable;
               me_w_data   = load_data;
            end
            // Leaving DONE lines up with EX_ME advancing to the next instruction.
            if (!stall[4]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         stallreq_me  = 1'b0;
         misalign_exc = 1'b0;
         me_w_enable  = 1'b0;
         me_w_addr    = 5'd0;
         me_w_data    = 32'h0;
         issue        = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Registered memory request; held stable from issue until the acknowledge edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         dm.dm_req   <= 1'b0;
         dm.dm_we    <= 1'b0;
         dm.dm_addr  <= '0;
         dm.dm_wdata <= 32'h0;
         dm.dm_be    <= 4'b0000;
         rdata_q     <= 32'h0;
      end else if (issue) begin
         dm.dm_req   <= 1'b1;
         dm.dm_we    <= is_store;
         dm.dm_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
         dm.dm_wdata <= wdata_c;
         dm.dm_be    <= be_c;
      end else if (ack_take) begin
         dm.dm_req   <= 1'b0;
         rdata_q     <= dm.dm_rdata;
      end
   end

endmodule

// File: tb/tb_me_lsu.sv
// Self-checking bench for me_lsu: directed scenarios with expected load results
// queued at issue time and popped when the stage reaches DONE.
module tb_me_lsu;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                          OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                          OP_SW = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_w_enable;
   logic [4:0]  ex_w_addr;
   logic [31:0] ex_w_data;
   logic [3:0]  ex_mem_op;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_wdata;
   logic [5:0]  stall;
   logic        me_w_enable;
   logic [4:0]  me_w_addr;
   logic [31:0] me_w_data;
   logic        stallreq_me;
   logic        misalign_exc;
   logic [1:0]  dbg_state;

   logic [31:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   me_lsu_if #(.ADDR_W(32)) bus ();

   me_lsu #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_w_enable  (ex_w_enable),
      .ex_w_addr    (ex_w_addr),
      .ex_w_data    (ex_w_data),
      .ex_mem_op    (ex_mem_op),
      .ex_mem_addr  (ex_mem_addr),
      .ex_mem_wdata (ex_mem_wdata),
      .stall        (stall),
      .me_w_enable  (me_w_enable),
      .me_w_addr    (me_w_addr),
      .me_w_data    (me_w_data),
      .stallreq_me  (stallreq_me),
      .misalign_exc (misalign_exc),
      .dbg_state    (dbg_state),
      .dm           (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one load/store from IDLE through DONE and back to IDLE.
   task automatic do_mem(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input int stalls, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic is_load,
                         input logic [31:0] load_exp);
      int stall_cnt = 0;
      int req_cnt = 0;
      logic [31:0] exp_v;
      if (is_load) exp_q.push_back(load_exp);
      ex_w_enable  = 1'b1;
      ex_w_addr    = 5'd9;
      ex_w_data    = 32'hA5A5A5A5;
      ex_mem_op    = op;
      ex_mem_addr  = addr;
      ex_mem_wdata = wdata;
      #1;
      checks++;
      if (stallreq_me !== 1'b1) begin
         errors++;
         $display("FAIL %s issue stallreq_me got %0b want 1", name, stallreq_me);
      end
      if (stallreq_me === 1'b1) stall_cnt++;
      for (int i = 0; i <= waits; i++) begin
         tick();
         bus.dm_ack   = (i == waits);
         bus.dm_rdata = (i == waits) ? rdata : 32'h0;
         #1;
         if (stallreq_me === 1'b1) stall_cnt++;
         if (bus.dm_req === 1'b1) req_cnt++;
         checks++;
         if (dbg_state !== S_REQ || bus.dm_req !== 1'b1) begin
            errors++;
            $display("FAIL %s req state=%0d dm_req=%0b want state=%0d dm_req=1",
                     name, dbg_state, bus.dm_req, S_REQ);
         end
         checks++;
         if (bus.dm_addr !== (addr & 32'hFFFF_FFFC) || bus.dm_be !== exp_be ||
             bus.dm_we !== !is_load) begin
            errors++;
            $display("FAIL %s bus addr=%h be=%b we=%0b want addr=%h be=%b we=%0b", name,
                     bus.dm_addr, bus.dm_be, bus.dm_we, addr & 32'hFFFF_FFFC, exp_be, !is_load);
         end
         if (!is_load) begin
            checks++;
            if (bus.dm_wdata !== exp_wdata) begin
               errors++;
               $display("FAIL %s dm_wdata got %h want %h", name, bus.dm_wdata, exp_wdata);
            end
         end
      end
      tick();
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = 32'hDEAD_0000;
      stall[4]     = (stalls > 0);
      #1;
      checks++;
      if (dbg_state !== S_DONE || bus.dm_req !== 1'b0 || stallreq_me !== 1'b0) begin
         errors++;
         $display("FAIL %s done state=%0d dm_req=%0b stallreq=%0b want %0d/0/0",
                  name, dbg_state, bus.dm_req, stallreq_me, S_DONE);
      end
      checks++;
      if (me_w_enable !== is_load || me_w_addr !== 5'd9) begin
         errors++;
         $display("FAIL %s done w_enable=%0b w_addr=%0d want %0b/9",
                  name, me_w_enable, me_w_addr, is_load);
      end
      if (is_load) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty at DONE", name);
         end else begin
            exp_v = exp_q.pop_front();
            if (me_w_data !== exp_v) begin
               errors++;
               $display("FAIL %s load data got %h want %h", name, me_w_data, exp_v);
            end
         end
      end
      for (int k = 1; k <= stalls; k++) begin
         tick();
         stall[4] = (k < stalls);
         #1;
         checks++;
         if (dbg_state !== S_DONE || bus.dm_req !== 1'b0) begin
            errors++;
            $display("FAIL %s held state=%0d dm_req=%0b want %0d/0",
                     name, dbg_state, bus.dm_req, S_DONE);
         end
      end
      tick();
      ex_mem_op   = OP_NONE;
      ex_w_enable = 1'b0;
      #1;
      checks++;
      if (dbg_state !== S_IDLE || bus.dm_req !== 1'b0) begin
         errors++;
         $display("FAIL %s exit state=%0d dm_req=%0b want %0d/0",
                  name, dbg_state, bus.dm_req, S_IDLE);
      end
      checks++;
      if (stall_cnt != waits + 2 || req_cnt != waits + 1) begin
         errors++;
         $display("FAIL %s cycles stallreq=%0d dm_req=%0d want %0d/%0d",
                  name, stall_cnt, req_cnt, waits + 2, waits + 1);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      ex_w_enable  = 1'b1;
      ex_w_addr    = 5'd5;
      ex_w_data    = 32'h0000_0123;
      ex_mem_op    = OP_LW;
      ex_mem_addr  = 32'h1000;
      ex_mem_wdata = 32'h0;
      stall        = 6'd0;
      bus.dm_ack   = 1'b0;
      bus.dm_rdata = 32'h0;
      tick();
      tick();
      checks++;
      if (dbg_state !== S_IDLE || bus.dm_req !== 1'b0 || bus.dm_be !== 4'b0000 ||
          bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0 || bus.dm_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs state=%0d req=%0b be=%b addr=%h wdata=%h we=%0b want all 0",
                  dbg_state, bus.dm_req, bus.dm_be, bus.dm_addr, bus.dm_wdata, bus.dm_we);
      end
      checks++;
      if (me_w_enable !== 1'b0 || me_w_addr !== 5'd0 || me_w_data !== 32'h0 ||
          stallreq_me !== 1'b0 || misalign_exc !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs en=%0b addr=%0d data=%h stallreq=%0b mis=%0b want all 0",
                  me_w_enable, me_w_addr, me_w_data, stallreq_me, misalign_exc);
      end
      rst       = 1'b0;
      ex_mem_op = OP_NONE;
      tick();
   endtask

   task automatic test_alu_pass();
      ex_mem_op   = OP_NONE;
      ex_w_enable = 1'b1;
      ex_w_addr   = 5'd5;
      ex_w_data   = 32'h1234_5678;
      #1;
      checks++;
      if (me_w_enable !== 1'b1 || me_w_addr !== 5'd5 || me_w_data !== 32'h1234_5678 ||
          stallreq_me !== 1'b0) begin
         errors++;
         $display("FAIL alu_pass en=%0b addr=%0d data=%h stallreq=%0b want 1/5/12345678/0",
                  me_w_enable, me_w_addr, me_w_data, stallreq_me);
      end
      // An unused encoding must also behave as NONE.
      ex_mem_op = 4'd12;
      ex_w_data = 32'h0BAD_F00D;
      tick();
      checks++;
      if (bus.dm_req !== 1'b0 || me_w_data !== 32'h0BAD_F00D || stallreq_me !== 1'b0) begin
         errors++;
         $display("FAIL alu_bad_op dm_req=%0b data=%h stallreq=%0b want 0/0badf00d/0",
                  bus.dm_req, me_w_data, stallreq_me);
      end
      ex_mem_op   = OP_NONE;
      ex_w_enable = 1'b0;
   endtask

   task automatic test_lb_zero_wait();
      do_mem("lb", OP_LB, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, 0, 4'b1000, 32'h0,
             1'b1, 32'hFFFF_FF80);
      do_mem("lbu", OP_LBU, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, 0, 4'b1000, 32'h0,
             1'b1, 32'h0000_0080);
   endtask

   task automatic test_sh_wait_states();
      do_mem("sh_wait3", OP_SH, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0, 4'b1100,
             32'hBEEF_BEEF, 1'b0, 32'h0);
   endtask

   task automatic test_misaligned();
      logic [3:0]  ops[3]   = '{OP_LW, OP_SH, OP_LHU};
      logic [31:0] addrs[3] = '{32'h3001, 32'h2001, 32'h1003};
      for (int i = 0; i < 3; i++) begin
         ex_w_enable = 1'b1;
         ex_w_addr   = 5'd3;
         ex_mem_op   = ops[i];
         ex_mem_addr = addrs[i];
         #1;
         checks++;
         if (misalign_exc !== 1'b1 || stallreq_me !== 1'b0 || me_w_enable !== 1'b0) begin
            errors++;
            $display("FAIL misalign_%0d mis=%0b stallreq=%0b en=%0b want 1/0/0",
                     i, misalign_exc, stallreq_me, me_w_enable);
         end
         tick();
         ex_mem_op   = OP_NONE;
         ex_w_enable = 1'b0;
         #1;
         checks++;
         if (bus.dm_req !== 1'b0 || dbg_state !== S_IDLE || misalign_exc !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after_%0d dm_req=%0b state=%0d mis=%0b want 0/%0d/0",
                     i, bus.dm_req, dbg_state, misalign_exc, S_IDLE);
         end
      end
   endtask

   task automatic test_ext_stall();
      do_mem("lw_stall2", OP_LW, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1, 2, 4'b1111, 32'h0,
             1'b1, 32'hDEAD_BEEF);
   endtask

   task automatic test_back_to_back();
      do_mem("sb", OP_SB, 32'h4001, 32'h1234_5678, 32'h0, 0, 0, 4'b0010, 32'h7878_7878,
             1'b0, 32'h0);
      do_mem("sw", OP_SW, 32'h4000, 32'h1234_5678, 32'h0, 2, 0, 4'b1111, 32'h1234_5678,
             1'b0, 32'h0);
      do_mem("lh", OP_LH, 32'h1002, 32'h0, 32'h80AA_BBCC, 0, 0, 4'b1100, 32'h0,
             1'b1, 32'hFFFF_80AA);
      do_mem("lhu", OP_LHU, 32'h1000, 32'h0, 32'h80AA_BBCC, 1, 0, 4'b0011, 32'h0,
             1'b1, 32'h0000_BBCC);
      do_mem("lb_pos", OP_LB, 32'h1001, 32'h0, 32'h0000_3400, 0, 0, 4'b0010, 32'h0,
             1'b1, 32'h0000_0034);
      do_mem("lb_l0", OP_LB, 32'h1000, 32'h0, 32'h80AA_BBCC, 0, 1, 4'b0001, 32'h0,
             1'b1, 32'hFFFF_FFCC);
   endtask

   task automatic test_reset_during_req();
      ex_w_enable = 1'b1;
      ex_w_addr   = 5'd11;
      ex_mem_op   = OP_LW;
      ex_mem_addr = 32'h5000;
      tick();
      checks++;
      if (bus.dm_req !== 1'b1 || dbg_state !== S_REQ) begin
         errors++;
         $display("FAIL rst_req_setup dm_req=%0b state=%0d want 1/%0d",
                  bus.dm_req, dbg_state, S_REQ);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bus.dm_req !== 1'b0 || dbg_state !== S_IDLE || me_w_enable !== 1'b0) begin
         errors++;
         $display("FAIL rst_req_drop dm_req=%0b state=%0d en=%0b want 0/%0d/0",
                  bus.dm_req, dbg_state, me_w_enable, S_IDLE);
      end
      rst          = 1'b0;
      ex_mem_op    = OP_NONE;
      ex_w_enable  = 1'b0;
      bus.dm_ack   = 1'b1;
      bus.dm_rdata = 32'hCAFE_F00D;
      tick();
      bus.dm_ack = 1'b0;
      #1;
      checks++;
      if (dbg_state !== S_IDLE || bus.dm_req !== 1'b0 || me_w_enable !== 1'b0 ||
          stallreq_me !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_ack state=%0d dm_req=%0b en=%0b stallreq=%0b want %0d/0/0/0",
                  dbg_state, bus.dm_req, me_w_enable, stallreq_me, S_IDLE);
      end
      tick();
      checks++;
      if (dbg_state !== S_IDLE || bus.dm_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_late_ack_hold state=%0d dm_req=%0b want %0d/0",
                  dbg_state, bus.dm_req, S_IDLE);
      end
   endtask

   initial begin
      test_reset();
      test_alu_pass();
      test_lb_zero_wait();
      test_sh_wait_states();
      test_misaligned();
      test_ext_stall();
      test_back_to_back();
      test_reset_during_req();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/me_lsu.md
# me_lsu

Memory-access stage of the RV32I pipeline, between the EX_ME pipeline register and the ME_WB register. For loads and stores it aligns data, generates byte enables and runs a request/acknowledge transaction with data memory. It holds the pipeline through `stallreq_me` until the memory acknowledges. For every other instruction it passes the register-write triple through unchanged.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_w_enable` in 1: rd write enable from EX_ME.
- `ex_w_addr` in 5: rd index.
- `ex_w_data` in 32: ALU result.
- `ex_mem_op` in 4: memory op encoding. 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW. Other values are treated as NONE.
- `ex_mem_addr` in ADDR_W: effective address.
- `ex_mem_wdata` in 32: store data (rs2).
- `stall` in 6: pipeline stall vector; bit 4 = ME stage held.
- `me_w_enable` out 1, `me_w_addr` out 5, `me_w_data` out 32: register-write triple to ME_WB.
- `stallreq_me` out 1: stall request to the stall controller.
- `misalign_exc` out 1: misaligned-access flag, one cycle.
- `dm_req` out 1: memory request, registered.
- `dm_we` out 1: 1 = store, 0 = load.
- `dm_addr` out ADDR_W: word address, with [1:0] forced to 0.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_be` out 4: byte enables.
- `dm_ack` in 1: memory done; read data valid in the same cycle.
- `dm_rdata` in 32: read word.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE, op NONE:**
  - `me_w_*` = `ex_w_*` combinationally.
  - `stallreq_me`=0; no memory activity.
- **IDLE, op valid and aligned:**
  - `stallreq_me`=1 combinationally.
  - Register `dm_req`=1, `dm_we`, `dm_addr`, `dm_be`, `dm_wdata`.
  - Next state REQ.
- **REQ:**
  - `stallreq_me`=1; `dm_*` held stable.
  - On `dm_ack`=1: capture `dm_rdata` into `rdata_q`, clear `dm_req` at the same edge, go to DONE.
- **DONE:**
  - `stallreq_me`=0.
  - Load: `me_w_enable`=`ex_w_enable`, `me_w_data`=extended `rdata_q`.
  - Store: `me_w_enable`=0.
  - `me_w_addr`=`ex_w_addr`.
  - Go to IDLE when `stall[4]`=0; otherwise stay in DONE and issue no new request.
- **Alignment:**
  - LH, LHU, SH are misaligned when addr[0]=1.
  - LW, SW are misaligned when addr[1:0]≠0.
  - Byte ops are never misaligned.
- **Misaligned access (IDLE only):**
  - `misalign_exc`=1 for that cycle; no request issued.
  - `me_w_enable`=0; `stallreq_me`=0; stay in IDLE.
- **Byte enables, with lane = addr[1:0]:**
  - Byte ops: 1<<lane.
  - Halfword ops: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - Word ops: 4'b1111.
  - Loads drive the same `dm_be` with `dm_we`=0.
- **Store data:**
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: word unchanged.
- **Load extract:**
  - LB, LBU: byte at lane; LB sign-extends bit 7, LBU zero-extends.
  - LH, LHU: halfword at addr[1]; LH sign-extends bit 15, LHU zero-extends.
  - LW: full word.
- **Ignored input:** `dm_ack` in IDLE or DONE has no effect.

## Timing
- **Reset:** while `rst`=1 at an edge:
  - State becomes IDLE.
  - `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_be`, `rdata_q` become 0.
  - While `rst` is high, `me_w_enable`=0, `me_w_addr`=0, `me_w_data`=0, `stallreq_me`=0, `misalign_exc`=0.
- **Reset mid-transaction:** `rst` in REQ drops `dm_req` at that edge. A later `dm_ack` is ignored.
- **Non-memory ops:** 0 extra cycles.
- **Load/store with zero-wait memory:**
  - Cycle 0: IDLE, decision.
  - Cycle 1: REQ, `dm_ack` sampled.
  - Cycle 2: DONE.
  - The ME stage is occupied for 3 cycles.
- **Wait states:** each cycle `dm_ack` stays low adds one cycle in REQ.
- **One access per instruction:** `dm_req` is high for exactly the REQ cycles of one transaction, so a store is never issued twice. EX_ME holds its inputs while `stallreq_me`=1.
- **DONE→IDLE edge:** coincides with EX_ME advancing, so the next instruction is seen in IDLE the following cycle.

## Test plan
- **ALU pass-through:** op NONE, `ex_w_enable`=1, addr=5, data=0x12345678 → same cycle `me_w_*`=(1, 5, 0x12345678), `stallreq_me`=0, `dm_req` stays 0.
- **LB zero-wait:** addr=0x1003, `dm_rdata`=0x80AABBCC, ack in the first REQ cycle:
  - `dm_addr`=0x1000, `dm_be`=4'b1000.
  - DONE `me_w_data`=0xFFFFFF80.
  - Repeat with LBU → 0x00000080.
  - `stallreq_me` high for exactly 2 cycles.
- **SH with 3 wait states:** addr=0x2002, wdata=0x0000BEEF:
  - `dm_we`=1, `dm_be`=4'b1100, `dm_wdata`=0xBEEFBEEF.
  - `dm_req` high for 4 cycles.
  - DONE `me_w_enable`=0.
- **Misaligned LW:** addr=0x3001 → `misalign_exc`=1 for one cycle, `dm_req`=0, `me_w_enable`=0, `stallreq_me`=0.
- **External stall in DONE:** `stall[4]`=1 held for 2 cycles → state stays DONE, no second `dm_req`; IDLE on the first cycle with `stall[4]`=0.
- **Reset during REQ:** assert `rst` while `dm_req`=1:
  - Next cycle `dm_req`=0 and state is IDLE.
  - A late `dm_ack`=1 produces no write and no DONE.
